// File: rtl/timer_arb_if.sv
// Request/grant bundle between the requesters and the shared-timebase arbiter.
interface timer_arb_if;
  logic [3:0]  req;
  logic [31:0] dly;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        tick;

  // Requester side drives requests and delays, observes grant/completion.
  modport master (
    output req, dly,
    input  gnt, done, busy, tick
  );

  // Arbiter side.
  modport slave (
    input  req, dly,
    output gnt, done, busy, tick
  );
endinterface

// File: rtl/timer_arb.sv
// Round-robin arbiter granting one of four requesters a prescaled timebase
// for a requested number of ticks, then pulsing done to that requester.
module timer_arb #(
  parameter int unsigned DIV = 25000000,
  parameter int unsigned CW  = 25
) (
  input  logic        ck,
  input  logic        rst,
  timer_arb_if.slave  bus
);

  localparam logic [CW-1:0] PMAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    win_q, win_d;
  logic [1:0]    last_q, last_d;
  logic [7:0]    rem_q, rem_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    done_q, done_d;
  logic          busy_q, busy_d;
  logic          tick_q, tick_d;

  logic [1:0]    sel;
  logic [1:0]    idx;
  logic          found;
  logic [7:0]    sel_dly;

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.tick = tick_q;

  // Round-robin pick: first active request after the last granted index.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && bus.req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    sel_dly = bus.dly[{sel, 3'b000} +: 8];
  end

  // State and datapath registers, including the registered outputs.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= 2'd3;
      rem_q   <= '0;
      pre_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

  // Next state: arbitration, prescaler/remaining-tick counting, abort.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    unique case (state_q)
      IDLE: begin
        pre_d = '0;
        if (found) begin
          win_d   = sel;
          rem_d   = sel_dly;
          state_d = (sel_dly != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!bus.req[win_q]) begin
          // Requester withdrew: release the timebase without completion.
          state_d = IDLE;
          last_d  = win_q;
          pre_d   = '0;
        end else if (pre_q == PMAX) begin
          pre_d = '0;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = DONE;
          end
        end else begin
          pre_d = pre_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs register in step with it.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    busy_d = (state_d != IDLE);
    tick_d = 1'b0;
    if (state_d == RUN) begin
      gnt_d  = 4'b0001 << win_d;
      tick_d = (pre_d == PMAX);
    end
    if (state_d == DONE) begin
      done_d = 4'b0001 << win_d;
    end
  end

endmodule

// File: tb/tb_timer_arb.sv
// Scoreboard bench for timer_arb with DIV=4: stimulus queues expected
// grant/done/idle events, a monitor reconstructs them from the outputs.
module tb_timer_arb;

  localparam int unsigned DIV = 4;

  logic ck;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    byte        kind;
    logic [3:0] val;
    int         len;
    int         ticks;
  } ev_t;

  ev_t exp_q[$];

  timer_arb_if bus();

  timer_arb #(.DIV(DIV), .CW(4)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  initial begin
    total = 0;
    bad   = 0;
  end

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic expect_ev(input byte k, input logic [3:0] v, input int l, input int t);
    ev_t e;
    e.kind  = k;
    e.val   = v;
    e.len   = l;
    e.ticks = t;
    exp_q.push_back(e);
  endtask

  task automatic emit(input byte k, input logic [3:0] v, input int l, input int t);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%s val=%b len=%0d ticks=%0d, want none", k, v, l, t);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.len != l || e.ticks != t) begin
        bad++;
        $display("FAIL event: got kind=%s val=%b len=%0d ticks=%0d, want kind=%s val=%b len=%0d ticks=%0d",
                 k, v, l, t, e.kind, e.val, e.len, e.ticks);
      end
    end
  endtask

  // Monitor: rebuilds grant windows, done pulses and busy windows.
  initial begin : monitor
    logic [3:0] pg;
    logic       pb;
    int         gc;
    int         tc;
    int         bc;
    pg = '0; pb = 1'b0; gc = 0; tc = 0; bc = 0;
    forever begin
      @(negedge ck);
      if (rst) begin
        pg = '0; pb = 1'b0; gc = 0; tc = 0; bc = 0;
      end else begin
        check("gnt_onehot", int'($countones(bus.gnt) <= 1), 1);
        check("done_onehot", int'($countones(bus.done) <= 1), 1);
        check("tick_outside_gnt", int'(bus.tick && bus.gnt == 4'b0000), 0);
        if (bus.busy) bc++;
        if (bus.gnt != 4'b0000) begin
          gc++;
          if (bus.tick) tc++;
        end else if (pg != 4'b0000) begin
          emit("G", pg, gc, tc);
          gc = 0;
          tc = 0;
        end
        if (bus.done != 4'b0000) emit("D", bus.done, bc, 0);
        if (!bus.busy && pb) begin
          emit("B", 4'b0000, bc, 0);
          bc = 0;
        end
        pg = bus.gnt;
        pb = bus.busy;
      end
    end
  end

  task automatic wait_gnt(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge ck);
      if (bus.gnt != 4'b0000) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_done(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge ck);
      if (bus.done != 4'b0000) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic pulse_rst();
    @(posedge ck);
    #2 rst = 1'b1;
    #1;
    check("rst_async_gnt", int'(bus.gnt), 0);
    check("rst_async_busy", int'(bus.busy), 0);
    check("rst_async_done", int'(bus.done), 0);
    #5 rst = 1'b0;
  endtask

  initial begin : stimulus
    int c0;
    int c1;
    rst     = 1'b1;
    bus.req = 4'b0000;
    bus.dly = 32'h0;
    repeat (2) @(negedge ck);
    check("reset_gnt", int'(bus.gnt), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_tick", int'(bus.tick), 0);
    rst = 1'b0;
    @(negedge ck);

    // Single request, delay 3; dly changed mid-run must not matter.
    expect_ev("G", 4'b0001, 12, 3);
    expect_ev("D", 4'b0001, 13, 0);
    expect_ev("B", 4'b0000, 13, 0);
    bus.dly = 32'h0000_0003;
    bus.req = 4'b0001;
    wait_gnt("single_gnt_timeout", 10);
    bus.dly = 32'h0000_0009;
    wait_done("single_done_timeout", 40);
    bus.req = 4'b0000;
    repeat (2) @(negedge ck);

    // Zero delay: straight to DONE, no grant cycle.
    expect_ev("D", 4'b0100, 1, 0);
    expect_ev("B", 4'b0000, 1, 0);
    bus.dly = 32'h0000_0000;
    bus.req = 4'b0100;
    wait_done("zero_done_timeout", 10);
    bus.req = 4'b0000;
    repeat (2) @(negedge ck);

    // Contention from a fresh reset: order 0,1,2,3,0.
    pulse_rst();
    for (int k = 0; k < 5; k++) begin
      expect_ev("G", 4'b0001 << (k % 4), 4, 1);
      expect_ev("D", 4'b0001 << (k % 4), 5, 0);
      expect_ev("B", 4'b0000, 5, 0);
    end
    @(negedge ck);
    bus.dly = 32'h0101_0101;
    bus.req = 4'b1111;
    wait_gnt("rr_gnt_timeout", 10);
    c0 = cyc;
    for (int k = 0; k < 5; k++) wait_done("rr_done_timeout", 20);
    c1 = cyc;
    bus.req = 4'b0000;
    check("rr_span_cycles", c1 - c0, 28);
    repeat (2) @(negedge ck);

    // Abort after 6 RUN cycles, then index 0 wins the next arbitration.
    expect_ev("G", 4'b0010, 6, 1);
    expect_ev("B", 4'b0000, 6, 0);
    expect_ev("G", 4'b0001, 4, 1);
    expect_ev("D", 4'b0001, 5, 0);
    expect_ev("B", 4'b0000, 5, 0);
    bus.dly = 32'h0000_0501;
    bus.req = 4'b0010;
    wait_gnt("abort_gnt_timeout", 10);
    repeat (5) @(negedge ck);
    bus.req = 4'b0000;
    @(negedge ck);
    check("abort_busy_low", int'(bus.busy), 0);
    bus.req = 4'b0011;
    wait_done("abort_next_done_timeout", 20);
    bus.req = 4'b0000;
    repeat (2) @(negedge ck);

    // Async reset mid-run; requester 3 keeps asking and gets a full run.
    expect_ev("G", 4'b1000, 8, 2);
    expect_ev("D", 4'b1000, 9, 0);
    expect_ev("B", 4'b0000, 9, 0);
    bus.dly = 32'h0200_0000;
    bus.req = 4'b1000;
    wait_gnt("areset_gnt_timeout", 10);
    repeat (3) @(negedge ck);
    pulse_rst();
    wait_done("areset_done_timeout", 30);
    bus.req = 4'b0000;
    repeat (2) @(negedge ck);

    // Maximum delay.
    expect_ev("G", 4'b0001, 1020, 255);
    expect_ev("D", 4'b0001, 1021, 0);
    expect_ev("B", 4'b0000, 1021, 0);
    bus.dly = 32'h0000_00ff;
    bus.req = 4'b0001;
    wait_done("maxdly_done_timeout", 1100);
    bus.req = 4'b0000;
    repeat (3) @(negedge ck);

    check("events_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_arb.md
TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 Parameter DIV, default 25000000, clock cycles per timebase tick (legal range 2..2^25-1).
REQ-002 Parameter CW, default 25, prescaler counter width.
REQ-003 ck  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  level request per requester i; held high until done[i] or deliberately dropped to abort.
REQ-006 dly  input  32  packed delay, dly[8i+7:8i] = ticks requested by requester i, sampled only at grant.
REQ-007 gnt  output  4  one-hot grant, requester currently owning the shared timebase.
REQ-008 done  output  4  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 tick  output  1  one-cycle pulse at each prescaler wrap while in RUN.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE, with all outputs registered.
REQ-012 In IDLE with req!=0, the block SHALL select the winner round-robin, searching from index (last+1) mod 4 upward; last = index of the most recently granted requester, reset value 3.
REQ-013 On selection, the block SHALL latch the winner index and the winner's 8-bit delay into rem, zero the prescaler, and enter RUN if delay!=0 or DONE if delay==0.
REQ-014 gnt[winner] SHALL be high in the cycle after the selecting edge and stay high through RUN only; it SHALL be low in DONE and IDLE.
REQ-015 In RUN the prescaler SHALL count 0..DIV-1 and wrap to 0; tick SHALL pulse on the cycle the prescaler equals DIV-1.
REQ-016 On each wrap, rem SHALL decrement by 1; a wrap with rem==1 SHALL move the state to DONE.
REQ-017 The RUN duration SHALL be exactly delay*DIV cycles, so done rises delay*DIV+1 cycles after the selecting edge.
REQ-018 In DONE, done[winner] SHALL be high for exactly one cycle; the state SHALL then return to IDLE and last := winner.
REQ-019 If req[winner] falls during RUN, the block SHALL go to IDLE on the next edge with no done pulse, set last := winner, and clear the prescaler.
REQ-020 Requests arriving or changing while not in IDLE SHALL be ignored until IDLE; dly changes after the latch SHALL have no effect.
REQ-021 A requester still asserting req in IDLE after its done SHALL be regranted only when the round-robin order reaches it, so no requester waits more than 3 other grants.
REQ-022 At most one bit of gnt and at most one bit of done SHALL be high in any cycle.
REQ-023 Arbitration SHALL cost one IDLE cycle per grant: selection occurs on the first IDLE edge seeing req!=0.

Reset
REQ-024 While rst is high: state=IDLE, gnt=0, done=0, busy=0, tick=0, prescaler=0, rem=0, winner=0, last=3, all taking effect immediately, independent of ck.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release, arbitration SHALL restart from index 0.

Verification (DIV=4)
REQ-026 Single request: req=0001, dly[7:0]=3 -> gnt=0001 for 12 cycles, tick pulses at cycles 4, 8 and 12 of RUN, done=0001 for one cycle, busy falls the cycle after done.
REQ-027 Zero delay: req=0100, dly[23:16]=0 -> no gnt cycle, done=0100 one cycle after the selecting edge.
REQ-028 Contention: req=1111 held, all delays=1 -> grant order 0,1,2,3,0, each gnt lasting 4 cycles, one IDLE cycle between grants.
REQ-029 Abort: req=0010, dly=5, req[1] dropped after 6 RUN cycles -> IDLE next edge, done stays 0, next grant with req=0011 goes to index 0.
REQ-030 Async reset: rst pulsed mid-RUN between clock edges -> gnt and busy low immediately, no done, req=1000 after release is granted with full delay*DIV timing.
REQ-031 Max delay: dly=255 -> done exactly 1020 cycles after gnt rises; rem wraps never occur.
